// File: rtl/keypad_scan.sv
// keypad_scan: column-scanned 4x4 keypad front end with frame debounce and one-entry key event buffer.
// Latency: stable/key_held +1 edge, key_valid/key_code +2 edges after the frame-completing scan tick.
// Backpressure: one-entry valid/ack buffer; an event arriving while full without ack is dropped with key_overflow.
module keypad_scan #(
  parameter int CLK_FREQ        = 50000000,
  parameter int SCAN_HZ         = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] keyboard_row,
  output logic [3:0] keyboard_col,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ack,
  output logic       key_held,
  output logic       key_overflow
);

  localparam int            DIV      = CLK_FREQ / SCAN_HZ;
  localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TICK_VAL = PW'(DIV - 1);
  localparam logic [3:0]    DEB      = 4'(DEBOUNCE_FRAMES);

  // scan timing
  logic [PW-1:0] r_presc;
  logic [1:0]    r_col;
  logic [3:0]    r_col_drv;
  logic          w_tick;
  logic          w_frame_end;

  // row sampling
  logic [3:0]    r_row_s1;
  logic [3:0]    r_row_s2;
  logic [15:0]   r_raw;        // bit col*4+row = pressed
  logic          r_frame_done;

  // debounce
  logic [15:0]   w_snap;       // bit row*4+col = pressed, i.e. indexed by key code
  logic [15:0]   r_last_snap;
  logic [3:0]    r_match_cnt;
  logic [3:0]    w_cnt_next;
  logic [15:0]   r_stable;
  logic          w_accept;
  logic [15:0]   w_new_press;
  logic          w_low_vld;
  logic [3:0]    w_low_code;

  // event pipeline and buffer
  logic          r_evt_vld;
  logic [3:0]    r_evt_code;
  logic          r_key_valid;
  logic [3:0]    r_key_code;
  logic          r_key_overflow;

  assign w_tick      = (r_presc == TICK_VAL);
  assign w_frame_end = w_tick && (r_col == 2'd3);

  // Prescaler, column index and registered one-cold column drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc   <= '0;
      r_col     <= 2'd0;
      r_col_drv <= 4'b1110;
    end else if (w_tick) begin
      r_presc   <= '0;
      r_col     <= r_col + 2'd1;
      r_col_drv <= ~(4'b0001 << (r_col + 2'd1));
    end else begin
      r_presc   <= r_presc + PW'(1);
    end
  end

  // Two-flop row synchronizer, then capture the pressed rows of the driven column at the tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_s1     <= 4'hF;
      r_row_s2     <= 4'hF;
      r_raw        <= 16'h0;
      r_frame_done <= 1'b0;
    end else begin
      r_row_s1     <= keyboard_row;
      r_row_s2     <= r_row_s1;
      r_frame_done <= w_frame_end;
      if (w_tick) begin
        case (r_col)
          2'd0:    r_raw[3:0]   <= ~r_row_s2;
          2'd1:    r_raw[7:4]   <= ~r_row_s2;
          2'd2:    r_raw[11:8]  <= ~r_row_s2;
          default: r_raw[15:12] <= ~r_row_s2;
        endcase
      end
    end
  end

  // Reorder the column-major raw frame into key-code order (row*4 + col).
  always_comb begin
    w_snap = 16'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_snap[r*4 + c] = r_raw[c*4 + r];
      end
    end
  end

  // Run length of identical frames, saturating at the debounce depth.
  always_comb begin
    w_cnt_next = 4'd1;
    if (w_snap == r_last_snap) begin
      w_cnt_next = (r_match_cnt >= DEB) ? DEB : (r_match_cnt + 4'd1);
    end
  end

  assign w_accept    = r_frame_done && (w_cnt_next == DEB) && (w_snap != r_stable);
  assign w_new_press = w_snap & ~r_stable;

  // Lowest key code among the newly pressed keys; the others are discarded.
  always_comb begin
    w_low_vld  = 1'b0;
    w_low_code = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (w_new_press[i]) begin
        w_low_vld  = 1'b1;
        w_low_code = 4'(i);
      end
    end
  end

  // Debounce state, updated once per completed frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_snap <= 16'h0;
      r_match_cnt <= DEB;
      r_stable    <= 16'h0;
    end else if (r_frame_done) begin
      r_last_snap <= w_snap;
      r_match_cnt <= w_cnt_next;
      if (w_accept) begin
        r_stable <= w_snap;
      end
    end
  end

  // One-cycle event strobe on an accepted frame that adds at least one key.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_evt_vld  <= 1'b0;
      r_evt_code <= 4'd0;
    end else begin
      r_evt_vld  <= w_accept && w_low_vld;
      r_evt_code <= w_low_code;
    end
  end

  // One-entry event buffer: an ack in the event cycle frees the slot for the new event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_valid    <= 1'b0;
      r_key_code     <= 4'd0;
      r_key_overflow <= 1'b0;
    end else begin
      r_key_overflow <= 1'b0;
      if (r_evt_vld) begin
        if (!r_key_valid || key_ack) begin
          r_key_valid <= 1'b1;
          r_key_code  <= r_evt_code;
        end else begin
          r_key_overflow <= 1'b1;
        end
      end else if (key_ack) begin
        r_key_valid <= 1'b0;
      end
    end
  end

  assign keyboard_col = r_col_drv;
  assign key_valid    = r_key_valid;
  assign key_code     = r_key_code;
  assign key_held     = |r_stable;
  assign key_overflow = r_key_overflow;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: keypad matrix model driving keypad_scan, with a frame-level reference model.
// Latency: model predicts every output after each clock edge.
// Backpressure: key_ack driven directly or randomly by the bench.
module tb_keypad_scan;

  localparam int D   = 4;
  localparam int HSZ = 32768;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] keyboard_row;
  logic [3:0] keyboard_col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ack;
  logic       key_held;
  logic       key_overflow;

  logic [15:0] pressed;   // bit row*4+col

  int checks = 0;
  int errors = 0;
  int ovf_seen;

  // reference model state
  int          n;
  logic [15:0] hist [HSZ];
  logic [15:0] q [$];
  logic [15:0] m_stable;
  logic        m_held, m_held_next;
  int          m_held_at;
  int          m_evt_at;
  logic [3:0]  m_evt_code;
  logic        m_valid;
  logic [3:0]  m_code;
  logic        m_ovf;
  logic [3:0]  m_col;

  keypad_scan #(
    .CLK_FREQ(400),
    .SCAN_HZ(100),
    .DEBOUNCE_FRAMES(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .keyboard_row(keyboard_row),
    .keyboard_col(keyboard_col),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_ack(key_ack),
    .key_held(key_held),
    .key_overflow(key_overflow)
  );

  always #5 clk = ~clk;

  // Passive matrix: a row reads low when a pressed key sits in a driven (low) column.
  always_comb begin
    keyboard_row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4 + c] && (keyboard_col[c] == 1'b0)) keyboard_row[r] = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    q.delete();
    repeat (D) q.push_back(16'h0);
    m_stable = 16'h0; m_held = 1'b0; m_held_next = 1'b0; m_held_at = -1;
    m_evt_at = -1; m_evt_code = 4'd0;
    m_valid = 1'b0; m_code = 4'd0; m_ovf = 1'b0; m_col = 4'b1110;
  endtask

  // Advance the model by one clock edge (edge number n since reset release).
  task automatic model_edge(input logic ack);
    logic [15:0] snap, np;
    logic        all_eq;
    m_ovf = 1'b0;
    if (m_evt_at == n) begin
      if (!m_valid || ack) begin
        m_valid = 1'b1;
        m_code  = m_evt_code;
      end else begin
        m_ovf = 1'b1;
      end
      m_evt_at = -1;
    end else if (ack && m_valid) begin
      m_valid = 1'b0;
    end
    if (m_held_at == n) begin
      m_held = m_held_next;
      m_held_at = -1;
    end
    if ((n % 16) == 0) begin
      // column c of this frame was sampled from the matrix 2 edges into its drive window
      snap = 16'h0;
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          snap[r*4 + c] = hist[n - 16 + 4*c + 2][r*4 + c];
      q.push_back(snap);
      void'(q.pop_front());
      all_eq = 1'b1;
      foreach (q[i]) if (q[i] != snap) all_eq = 1'b0;
      if (all_eq && (snap != m_stable)) begin
        np = snap & ~m_stable;
        m_stable    = snap;
        m_held_next = (snap != 16'h0);
        m_held_at   = n + 1;
        for (int i = 15; i >= 0; i--) begin
          if (np[i]) begin
            m_evt_code = 4'(i);
            m_evt_at   = n + 2;
          end
        end
      end
    end
    m_col = ~(4'b0001 << ((n / 4) % 4));
  endtask

  task automatic step(input logic ack);
    logic [15:0] hw;
    key_ack = ack;
    hw = pressed;
    @(posedge clk);
    n++;
    if (n < HSZ) hist[n] = hw;
    model_edge(ack);
    #1;
    chk("col", {12'h0, keyboard_col}, {12'h0, m_col});
    chk("valid", {15'h0, key_valid}, {15'h0, m_valid});
    chk("code", {12'h0, key_code}, {12'h0, m_code});
    chk("held", {15'h0, key_held}, {15'h0, m_held});
    chk("ovf", {15'h0, key_overflow}, {15'h0, m_ovf});
    if (key_overflow === 1'b1) ovf_seen++;
  endtask

  task automatic run(input int cyc);
    repeat (cyc) step(1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    key_ack = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_col", {12'h0, keyboard_col}, 16'h000E);
    chk("rst_valid", {15'h0, key_valid}, 16'h0);
    chk("rst_code", {12'h0, key_code}, 16'h0);
    chk("rst_held", {15'h0, key_held}, 16'h0);
    chk("rst_ovf", {15'h0, key_overflow}, 16'h0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    pressed = 16'h0;
    key_ack = 1'b0;
    rst     = 1'b1;
    ovf_seen = 0;
    model_reset();

    // reset then idle scanning
    do_reset();
    run(64);
    chk("idle_valid", {15'h0, key_valid}, 16'h0);
    chk("idle_held", {15'h0, key_held}, 16'h0);

    // steady press row 2 / col 1
    pressed[9] = 1'b1;
    run(6*16);
    chk("press9_valid", {15'h0, key_valid}, 16'h1);
    chk("press9_code", {12'h0, key_code}, 16'd9);
    chk("press9_held", {15'h0, key_held}, 16'h1);
    step(1'b1);
    chk("ack9_drop", {15'h0, key_valid}, 16'h0);
    pressed[9] = 1'b0;
    run(6*16);
    chk("rel9_valid", {15'h0, key_valid}, 16'h0);
    chk("rel9_held", {15'h0, key_held}, 16'h0);

    // bouncing press, then steady
    for (int t = 0; t < 80; t++) begin
      if ((t % 10) == 0) pressed[9] = ~pressed[9];
      step(1'b0);
    end
    chk("bounce_none", {15'h0, key_valid}, 16'h0);
    pressed[9] = 1'b1;
    run(6*16);
    chk("bounce_valid", {15'h0, key_valid}, 16'h1);
    chk("bounce_code", {12'h0, key_code}, 16'd9);
    step(1'b1);
    pressed[9] = 1'b0;
    run(6*16);

    // rows 0 and 3 of column 2 together
    pressed[2]  = 1'b1;
    pressed[14] = 1'b1;
    run(6*16);
    chk("multi_valid", {15'h0, key_valid}, 16'h1);
    chk("multi_code", {12'h0, key_code}, 16'd2);
    step(1'b1);
    run(6*16);
    chk("multi_single", {15'h0, key_valid}, 16'h0);
    pressed = 16'h0;
    run(6*16);

    // overflow with buffer full, then ack in the event cycle
    pressed[5] = 1'b1;
    run(6*16);
    chk("ovf_first", {12'h0, key_code}, 16'd5);
    ovf_seen = 0;
    pressed[7] = 1'b1;
    run(6*16);
    chk("ovf_pulses", ovf_seen[15:0], 16'd1);
    chk("ovf_keep", {12'h0, key_code}, 16'd5);
    chk("ovf_valid", {15'h0, key_valid}, 16'h1);
    pressed[12] = 1'b1;
    for (int t = 0; t < 6*16; t++) step(m_evt_at == n + 1);
    chk("ackload_valid", {15'h0, key_valid}, 16'h1);
    chk("ackload_code", {12'h0, key_code}, 16'd12);
    step(1'b1);
    pressed = 16'h0;
    run(6*16);

    // reset mid-frame with a buffered event and a key still held
    pressed[9] = 1'b1;
    run(6*16);
    chk("pre_rst_valid", {15'h0, key_valid}, 16'h1);
    run(7);
    do_reset();
    run(6*16);
    chk("post_rst_valid", {15'h0, key_valid}, 16'h1);
    chk("post_rst_code", {12'h0, key_code}, 16'd9);
    step(1'b1);
    pressed = 16'h0;
    run(6*16);

    // randomized key toggles with random acks
    for (int it = 0; it < 250; it++) begin
      int k;
      int w;
      k = int'($urandom_range(15, 0));
      pressed[k] = ~pressed[k];
      w = int'($urandom_range(60, 1));
      for (int t = 0; t < w; t++) step($urandom_range(7, 0) == 0);
    end
    pressed = 16'h0;
    for (int t = 0; t < 8*16; t++) step($urandom_range(3, 0) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
